bin2bcd_seq: RTL
================

# bin2bcd_seq

Sequential binary-to-BCD converter using shift-and-add-3 (double dabble). It sits between the up/down counter and the per-digit 7-segment decoders, and replaces the combinational divide/modulo digit extraction. The counter value is converted over BIN_W clock cycles. Each BCD nibble of the result drives one `segmentos_7` instance directly. The registered output holds the previous value during a conversion, so the displays never glitch.

## Interface
- BIN_W, default 8: width of the binary input. Must satisfy 2^BIN_W − 1 ≤ 10^DIGITS − 1.
- DIGITS, default 3: number of BCD digits produced. Digit 0 (units) is at bcd_out[3:0].
- clk, input, 1: system clock, rising-edge active.
- rst_a, input, 1: asynchronous, active-high reset.
- start, input, 1: conversion request. Sampled only when busy=0.
- auto_mode, input, 1: when 1, a conversion starts automatically whenever bin_in differs from the last captured value.
- bin_in, input, BIN_W: unsigned value to convert. Captured on the accepting edge only.
- bcd_out, output, 4*DIGITS: registered packed BCD result. Holds its value until the next done.
- busy, output, 1: conversion in progress.
- done, output, 1: one-cycle pulse. bcd_out is new in the same cycle.

## Operation
- States:
  - IDLE: waiting for a trigger.
  - SHIFT: iterating; a down-counter iter runs BIN_W−1..0.
- Trigger in IDLE: start=1, OR (auto_mode=1 AND bin_in ≠ last_bin).
- On trigger, at one edge:
  - bin_sh ← bin_in; last_bin ← bin_in.
  - bcd_acc ← 0.
  - iter ← BIN_W−1; state ← SHIFT; busy ← 1.
- Each SHIFT edge, for every digit: if nibble ≥ 5, add 3. Then shift {bcd_acc, bin_sh} left by 1.
- When iter=0 in SHIFT:
  - bcd_out ← final bcd_acc (post-shift value).
  - done ← 1; busy ← 0; state ← IDLE.
- Otherwise iter decrements.
- done is 0 on every edge except the one that completes a conversion.
- Arithmetic widths:
  - Add-3 is applied per nibble, 4-bit, with no carry between nibbles.
  - bcd_acc is 4*DIGITS bits; bits shifted out of its MSB are discarded. This cannot occur when the parameter constraint holds.
- Triggers while busy=1 are ignored: start and auto changes are not queued.
- In auto mode, a value change during SHIFT is picked up at the first IDLE cycle after completion. That works because last_bin still differs.
- start and auto trigger in the same cycle: a single conversion.
- Reset values:
  - bcd_out=0, busy=0, done=0.
  - state=IDLE; last_bin=0; bin_sh=0; bcd_acc=0; iter=0.
- With bin_in=0 after reset, auto mode does not trigger; bcd_out=0 is already consistent.
- Reset asserted mid-conversion:
  - All state returns to reset values immediately (asynchronous).
  - The partial result is lost and no done is issued.
  - Operation resumes on the first edge after rst_a deasserts.

## Timing
- Edge E0: trigger sampled, busy=1 from E0.
- Edges E1..E_BIN_W: the BIN_W iterations. At E_BIN_W, bcd_out updates, done=1, busy=0.
- Latency from trigger edge to done: BIN_W edges. With the default, done is high in the cycle after E8.
- Back-to-back: a trigger may be sampled at the edge that ends the done cycle (state is IDLE). Throughput is one conversion per BIN_W+1 cycles.
- bcd_out changes only at a done edge or at reset.
- busy and done are never high in the same cycle.
- No combinational path from any input to any output.

## Test plan
- Reset:
  - Stimulus: assert rst_a with clk running.
  - Required: bcd_out=12'h000, busy=0, done=0. After release with start=0 and auto_mode=0, no done for 20 cycles.
- Single conversion:
  - Stimulus: bin_in=8'd255, start=1 for one cycle at E0.
  - Required: busy=1 E0..E7; done=1 only after E8; bcd_out=12'h255. Repeat with 8'd0 → 12'h000 and 8'd109 → 12'h109.
- Ignored trigger:
  - Stimulus: start pulse with bin_in=8'd42; at E3, start=1 with bin_in=8'd99.
  - Required: exactly one done; bcd_out=12'h042; no second conversion.
- Auto mode:
  - Stimulus: auto_mode=1, bin_in steps 17 → 18, each held 20 cycles.
  - Required: two done pulses; bcd_out=12'h017 then 12'h018.
  - Stimulus: change to 19 at E2 of a conversion.
  - Required: a second done follows with 12'h019.
- Reset mid-operation:
  - Stimulus: start with 8'd200; assert rst_a at E4 for 2 cycles.
  - Required: bcd_out=0, busy=0 immediately; no done. A new start with 8'd200 then yields 12'h200.
- Counter configuration:
  - Stimulus: BIN_W=5, DIGITS=2; sweep 0..31 with start.
  - Required: each done arrives 5 edges after its trigger; bcd_out equals the decimal digits of the input, e.g. 31 → 8'h31. Back-to-back starts give done every 6 cycles.

Source files
------------

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter using shift-and-add-3 (double dabble).
// Latency: BIN_W edges from the trigger edge to done; bcd_out is registered and held between conversions.
// Backpressure: none. Triggers seen while busy are dropped, and auto mode re-arms from last_bin.
module bin2bcd_seq #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_a,
    input  logic                  start,
    input  logic                  auto_mode,
    input  logic [BIN_W-1:0]      bin_in,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  busy,
    output logic                  done
);

    localparam int BCD_W  = 4 * DIGITS;
    localparam int ITER_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic [BIN_W-1:0]   last_bin;
    logic [BIN_W-1:0]   bin_sh;
    logic [BCD_W-1:0]   bcd_acc;
    logic [BCD_W-1:0]   bcd_adj;
    logic [BCD_W-1:0]   bcd_shifted;
    logic [ITER_W-1:0]  iter;
    logic               trigger;
    logic               last_iter;

    // Per-nibble add-3 with no carry between digits.
    always_comb begin
        bcd_adj = bcd_acc;
        for (int d = 0; d < DIGITS; d++) begin
            if (bcd_acc[4*d +: 4] >= 4'd5) begin
                bcd_adj[4*d +: 4] = bcd_acc[4*d +: 4] + 4'd3;
            end
        end
    end

    assign bcd_shifted = {bcd_adj[BCD_W-2:0], bin_sh[BIN_W-1]};
    assign trigger     = (state == IDLE) && (start || (auto_mode && (bin_in != last_bin)));
    assign last_iter   = (iter == '0);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (trigger)   state_nx = SHIFT;
            SHIFT:   if (last_iter) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            bcd_out  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            last_bin <= '0;
            bin_sh   <= '0;
            bcd_acc  <= '0;
            iter     <= '0;
        end else begin
            done <= 1'b0;
            if (trigger) begin
                bin_sh   <= bin_in;
                last_bin <= bin_in;
                bcd_acc  <= '0;
                iter     <= ITER_W'(BIN_W - 1);
                busy     <= 1'b1;
            end else if (state == SHIFT) begin
                bcd_acc <= bcd_shifted;
                bin_sh  <= bin_sh << 1;
                if (last_iter) begin
                    bcd_out <= bcd_shifted;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                end else begin
                    iter <= iter - 1'b1;
                end
            end
        end
    end

endmodule
